// File: rtl/key_pulser.sv
// Push-button front end: per-key synchronizer, counter debouncer, press strobe
// and optional hold-to-auto-repeat. Raw keys are active-low; outputs are active-high.
module key_pulser #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] pulse,
  output logic [N_KEYS-1:0] held,
  output logic [N_KEYS-1:0] repeating
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT    = '1;
  localparam bit                REPEAT_ON   = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    REPEAT   = 2'd2
  } state_t;

  logic [N_KEYS-1:0] s1_reg;
  logic [N_KEYS-1:0] s2_reg;

  // Synchronizer resets to the released (high) level.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_reg <= '1;
      s2_reg <= '1;
    end else begin
      s1_reg <= key_n;
      s2_reg <= s1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
      logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
      logic              stable_reg, stable_next;
      logic              raw_pressed;
      logic              accept;
      state_t            state_reg, state_next;
      logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
      logic              pulse_reg, pulse_next;

      assign raw_pressed = ~s2_reg[gi];

      always_comb begin
        db_cnt_next = '0;
        stable_next = stable_reg;
        accept      = 1'b0;
        if (raw_pressed != stable_reg) begin
          if (db_cnt_reg == DB_LAST) begin
            accept      = 1'b1;
            stable_next = raw_pressed;
          end else begin
            db_cnt_next = db_cnt_reg + 1'b1;
          end
        end
      end

      // An accepted level change always toggles press/release, so it takes
      // priority over any repeat event landing on the same edge.
      always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        pulse_next    = 1'b0;
        case (state_reg)
          RELEASED: begin
            hold_cnt_next = '0;
            if (accept) begin
              state_next = PRESSED;
              pulse_next = 1'b1;
            end
          end
          PRESSED: begin
            if (accept) begin
              state_next    = RELEASED;
              hold_cnt_next = '0;
            end else if (REPEAT_ON && hold_cnt_reg == DELAY_LAST) begin
              state_next    = REPEAT;
              pulse_next    = 1'b1;
              hold_cnt_next = '0;
            end else if (hold_cnt_reg != HOLD_SAT) begin
              hold_cnt_next = hold_cnt_reg + 1'b1;
            end
          end
          REPEAT: begin
            if (accept) begin
              state_next    = RELEASED;
              hold_cnt_next = '0;
            end else if (hold_cnt_reg == PERIOD_LAST) begin
              pulse_next    = 1'b1;
              hold_cnt_next = '0;
            end else begin
              hold_cnt_next = hold_cnt_reg + 1'b1;
            end
          end
          default: begin
            state_next    = RELEASED;
            hold_cnt_next = '0;
          end
        endcase
      end

      always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
          db_cnt_reg   <= '0;
          stable_reg   <= 1'b0;
          state_reg    <= RELEASED;
          hold_cnt_reg <= '0;
          pulse_reg    <= 1'b0;
        end else begin
          db_cnt_reg   <= db_cnt_next;
          stable_reg   <= stable_next;
          state_reg    <= state_next;
          hold_cnt_reg <= hold_cnt_next;
          pulse_reg    <= pulse_next;
        end
      end

      assign pulse[gi]     = pulse_reg;
      assign held[gi]      = stable_reg;
      assign repeating[gi] = (state_reg == REPEAT);
    end
  endgenerate

endmodule
